// File: rtl/jtag_unlock_ctrl.sv
// jtag_unlock_ctrl: serial-key debug unlock FSM with a failed-attempt lockout.
// Build with JTAG_LOCKOUT_TIMER_EN to let LOCKOUT expire after LOCKOUT_CYCLES; otherwise it holds until reset.
module jtag_unlock_ctrl #(
   parameter int unsigned          KEY_WIDTH      = 32,
   parameter logic [KEY_WIDTH-1:0] UNLOCK_KEY     = 32'hA5C3_5A3C,
   parameter int unsigned          MAX_FAIL       = 3,
   parameter int unsigned          LOCKOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              lock_in,
   input  logic                              req_start,
   input  logic                              key_bit,
   input  logic                              key_bit_valid,
   input  logic                              relock,
   output logic                              dbg_enable,
   output logic                              busy,
   output logic                              unlock_ok,
   output logic                              unlock_fail,
   output logic                              lockout,
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

   localparam int unsigned FC_W  = $clog2(MAX_FAIL + 1);
   localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

   if (KEY_WIDTH < 2 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
      $error("jtag_unlock_ctrl: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      LOCKED,
      SHIFT,
      CHECK,
      UNLOCKED,
      LOCKOUT
   } state_t;

   state_t               state;
   logic [KEY_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]     bit_cnt;

`ifdef JTAG_LOCKOUT_TIMER_EN
   localparam int unsigned TMR_W = $clog2(LOCKOUT_CYCLES + 1);
   logic [TMR_W-1:0]     lock_timer;
`endif

   // Outputs are assigned alongside each transition so they always reflect the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOCKED;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         fail_count  <= '0;
         dbg_enable  <= 1'b0;
         busy        <= 1'b0;
         unlock_ok   <= 1'b0;
         unlock_fail <= 1'b0;
         lockout     <= 1'b0;
`ifdef JTAG_LOCKOUT_TIMER_EN
         lock_timer  <= '0;
`endif
      end else begin
         unlock_ok   <= 1'b0;
         unlock_fail <= 1'b0;
         if (lock_in && state != LOCKOUT) begin
            // Hard lock aborts everything without counting a failure.
            state      <= LOCKED;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            dbg_enable <= 1'b0;
            busy       <= 1'b0;
            lockout    <= 1'b0;
         end else begin
            case (state)
               LOCKED: begin
                  if (req_start) begin
                     state     <= SHIFT;
                     shift_reg <= '0;
                     bit_cnt   <= '0;
                     busy      <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (req_start) begin
                     shift_reg <= '0;
                     bit_cnt   <= '0;
                  end else if (key_bit_valid) begin
                     shift_reg <= {shift_reg[KEY_WIDTH-2:0], key_bit};
                     bit_cnt   <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == CNT_W'(KEY_WIDTH - 1)) begin
                        state <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  busy      <= 1'b0;
                  if (shift_reg == UNLOCK_KEY) begin
                     state      <= UNLOCKED;
                     dbg_enable <= 1'b1;
                     unlock_ok  <= 1'b1;
                     fail_count <= '0;
                  end else begin
                     unlock_fail <= 1'b1;
                     if (fail_count >= FC_W'(MAX_FAIL - 1)) begin
                        fail_count <= FC_W'(MAX_FAIL);
                        state      <= LOCKOUT;
                        lockout    <= 1'b1;
                     end else begin
                        fail_count <= fail_count + FC_W'(1);
                        state      <= LOCKED;
                     end
                  end
               end
               UNLOCKED: begin
                  if (relock) begin
                     state      <= LOCKED;
                     dbg_enable <= 1'b0;
                  end
               end
               LOCKOUT: begin
`ifdef JTAG_LOCKOUT_TIMER_EN
                  if (lock_timer == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                     state      <= LOCKED;
                     lockout    <= 1'b0;
                     fail_count <= '0;
                     lock_timer <= '0;
                  end else begin
                     lock_timer <= lock_timer + TMR_W'(1);
                  end
`else
                  lockout <= 1'b1;
`endif
               end
               default: begin
                  state      <= LOCKED;
                  shift_reg  <= '0;
                  bit_cnt    <= '0;
                  dbg_enable <= 1'b0;
                  busy       <= 1'b0;
                  lockout    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Scoreboard bench for jtag_unlock_ctrl; covers the JTAG_LOCKOUT_TIMER_EN build when that macro is defined.
module tb_jtag_unlock_ctrl;

   localparam int unsigned KW       = 32;
   localparam logic [31:0] KEY      = 32'hA5C3_5A3C;
   localparam int unsigned LOCK_CYC = 1024;

   typedef enum int { EXP_OK, EXP_FAIL, EXP_NONE } exp_kind_t;
   typedef struct {
      logic        ok;
      int unsigned cyc;
      logic [1:0]  fc;
   } sb_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       lock_in = 1'b0, req_start = 1'b0, key_bit = 1'b0, key_bit_valid = 1'b0, relock = 1'b0;
   logic       dbg_enable, busy, unlock_ok, unlock_fail, lockout;
   logic [1:0] fail_count;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   int unsigned t0;
   sb_t         sb_q[$];

   jtag_unlock_ctrl #(
      .KEY_WIDTH(KW),
      .UNLOCK_KEY(KEY),
      .MAX_FAIL(3),
      .LOCKOUT_CYCLES(LOCK_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .lock_in(lock_in),
      .req_start(req_start),
      .key_bit(key_bit),
      .key_bit_valid(key_bit_valid),
      .relock(relock),
      .dbg_enable(dbg_enable),
      .busy(busy),
      .unlock_ok(unlock_ok),
      .unlock_fail(unlock_fail),
      .lockout(lockout),
      .fail_count(fail_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Every pulse must match the oldest expected result, including its cycle and fail count.
   always @(negedge clk) begin
      sb_t e;
      if (unlock_ok === 1'b1 || unlock_fail === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'({unlock_ok, unlock_fail}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("pulse_kind", 32'({unlock_ok, unlock_fail}), e.ok ? 32'd2 : 32'd1);
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_fc", 32'(fail_count), 32'(e.fc));
         end
      end
   end

   task automatic send_bits(input logic [31:0] key, input int unsigned n);
      for (int i = KW - 1; i >= int'(KW - n); i--) begin
         key_bit       = key[i];
         key_bit_valid = 1'b1;
         tick();
      end
      key_bit_valid = 1'b0;
   endtask

   task automatic attempt(input logic [31:0] key, input exp_kind_t kind, input logic [1:0] fc);
      sb_t e;
      req_start = 1'b1;
      tick();
      req_start = 1'b0;
      for (int i = KW - 1; i >= 0; i--) begin
         key_bit       = key[i];
         key_bit_valid = 1'b1;
         if (i == 0 && kind != EXP_NONE) begin
            e.ok  = (kind == EXP_OK);
            e.cyc = cyc + 2;
            e.fc  = fc;
            sb_q.push_back(e);
         end
         tick();
      end
      key_bit_valid = 1'b0;
      if (kind != EXP_NONE) begin
         check("busy_in_check", 32'(busy), 32'd1);
         check("dbg_in_check", 32'(dbg_enable), 32'd0);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset overrides active inputs.
      req_start     = 1'b1;
      key_bit_valid = 1'b1;
      tick();
      tick();
      check("rst_dbg", 32'(dbg_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ok", 32'(unlock_ok), 32'd0);
      check("rst_fail", 32'(unlock_fail), 32'd0);
      check("rst_lockout", 32'(lockout), 32'd0);
      check("rst_fc", 32'(fail_count), 32'd0);
      reset         = 1'b0;
      req_start     = 1'b0;
      key_bit_valid = 1'b0;
      tick();

      // Correct key, then UNLOCKED ignores req_start, then relock.
      attempt(KEY, EXP_OK, 2'd0);
      check("unlock_dbg", 32'(dbg_enable), 32'd1);
      check("unlock_busy", 32'(busy), 32'd0);
      check("unlock_fc", 32'(fail_count), 32'd0);
      req_start = 1'b1;
      tick();
      req_start = 1'b0;
      tick();
      check("unl_start_busy", 32'(busy), 32'd0);
      check("unl_start_dbg", 32'(dbg_enable), 32'd1);
      relock = 1'b1;
      tick();
      relock = 1'b0;
      check("relock_dbg", 32'(dbg_enable), 32'd0);

      // lock_in while unlocked; req_start ignored under lock_in.
      attempt(KEY, EXP_OK, 2'd0);
      lock_in = 1'b1;
      tick();
      check("lockin_dbg", 32'(dbg_enable), 32'd0);
      req_start = 1'b1;
      tick();
      tick();
      check("lockin_start", 32'(busy), 32'd0);
      req_start = 1'b0;
      lock_in   = 1'b0;
      tick();
      check("lockin_release", 32'(busy), 32'd0);

      // lock_in aborts a shift in progress without a failure.
      req_start = 1'b1;
      tick();
      req_start = 1'b0;
      send_bits(KEY, 10);
      check("abort_busy_pre", 32'(busy), 32'd1);
      lock_in = 1'b1;
      tick();
      lock_in = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_fc", 32'(fail_count), 32'd0);

      // 20 bits, restart, full correct key.
      req_start = 1'b1;
      tick();
      req_start = 1'b0;
      send_bits(32'hFFFF_F000, 20);
      attempt(KEY, EXP_OK, 2'd0);
      check("restart_dbg", 32'(dbg_enable), 32'd1);
      check("restart_fc", 32'(fail_count), 32'd0);
      relock = 1'b1;
      tick();
      relock = 1'b0;

      // One failure, then reset during CHECK of a correct key.
      attempt(32'h0, EXP_FAIL, 2'd1);
      check("fail1_lockout", 32'(lockout), 32'd0);
      req_start = 1'b1;
      tick();
      req_start = 1'b0;
      send_bits(KEY, 32);
      check("rst_chk_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_chk_dbg", 32'(dbg_enable), 32'd0);
      check("rst_chk_busy2", 32'(busy), 32'd0);
      check("rst_chk_ok", 32'(unlock_ok), 32'd0);
      check("rst_chk_fc", 32'(fail_count), 32'd0);
      tick();
      check("rst_chk_dbg2", 32'(dbg_enable), 32'd0);

      // Three failures -> lockout; further inputs ignored.
      attempt(32'h0, EXP_FAIL, 2'd1);
      attempt(32'h0, EXP_FAIL, 2'd2);
      check("fail2_lockout", 32'(lockout), 32'd0);
      attempt(32'h0, EXP_FAIL, 2'd3);
      t0 = cyc;
      check("lockout_set", 32'(lockout), 32'd1);
      check("lockout_busy", 32'(busy), 32'd0);
      attempt(KEY, EXP_NONE, 2'd0);
      check("lockout_key_dbg", 32'(dbg_enable), 32'd0);
      check("lockout_key_fc", 32'(fail_count), 32'd3);
      lock_in = 1'b1;
      relock  = 1'b1;
      tick();
      lock_in = 1'b0;
      relock  = 1'b0;
      check("lockout_lockin", 32'(lockout), 32'd1);

`ifdef JTAG_LOCKOUT_TIMER_EN
      while (cyc < t0 + LOCK_CYC - 1) tick();
      check("timer_hold", 32'(lockout), 32'd1);
      tick();
      check("timer_expire", 32'(lockout), 32'd0);
      check("timer_fc", 32'(fail_count), 32'd0);
      attempt(KEY, EXP_OK, 2'd0);
      check("timer_unlock", 32'(dbg_enable), 32'd1);
`else
      repeat (1100) tick();
      check("persist_lockout", 32'(lockout), 32'd1);
      check("persist_fc", 32'(fail_count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("persist_rst", 32'(lockout), 32'd0);
      check("persist_rst_fc", 32'(fail_count), 32'd0);
      attempt(KEY, EXP_OK, 2'd0);
      check("persist_unlock", 32'(dbg_enable), 32'd1);
`endif

      repeat (4) tick();
      check("sb_drain", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
